// File: rtl/ps2_uart_frame_tx.sv
// PS/2 scancode capture FIFO feeding a framed UART byte stream.
// Frame: HEADER, LEN, LEN payload bytes, optional XOR checksum; partial frames flush on idle timeout.
module ps2_uart_frame_tx #(
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned FRAME_LEN    = 4,
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter bit          CHK_EN       = 1'b1,
  parameter int unsigned FLUSH_CYCLES = 50_000_000
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             PS2_Done_Sig,
  input  logic [7:0]       KeyBoardData,
  input  logic             TX_Done_Sig,
  output logic             TX_En_Sig,
  output logic [7:0]       TX_Data,
  output logic [FIFO_AW:0] Fifo_Count,
  output logic             Overflow_Sig,
  output logic             Busy_Sig
);

  // state  | meaning
  // S_IDLE | waiting for a full frame or idle-timeout flush
  // S_SEND | TX_En_Sig high, TX_Data holds the current frame byte
  // S_GAP  | one low cycle between bytes; selects the next byte or ends the frame

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned TW    = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [TW-1:0]      TMR_LOAD  = TW'(FLUSH_CYCLES);
  localparam logic [TW-1:0]      TMR_ONE   = TW'(1);
  localparam logic [FIFO_AW:0]   DEPTH_W   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   FLEN_W    = (FIFO_AW + 1)'(FRAME_LEN);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  typedef enum logic [1:0] {P_HDR, P_LEN, P_PAY, P_CHK} phase_t;

  state_t             state, state_d;
  phase_t             phase, phase_d;
  logic [FIFO_AW:0]   idx, idx_d;
  logic [FIFO_AW:0]   len_q, len_d;
  logic [7:0]         chk_q, chk_d;
  logic [7:0]         data_q, data_d;

  logic               ps2_q, ps2_qq;
  logic [7:0]         kbd_q;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               ovf;
  logic [TW-1:0]      tmr;

  logic               capture, push, pop, start;
  logic               start_full, start_flush;
  logic [7:0]         rd_byte;

  assign capture     = ps2_q & ~ps2_qq;
  assign push        = capture && (count != DEPTH_W);
  assign start_full  = (count >= FLEN_W);
  assign start_flush = (FLUSH_CYCLES != 0) && (tmr == '0) && (count != '0);
  assign rd_byte     = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    phase_d = phase;
    idx_d   = idx;
    len_d   = len_q;
    chk_d   = chk_q;
    data_d  = data_q;
    pop     = 1'b0;
    start   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_full || start_flush) begin
          start   = 1'b1;
          state_d = S_SEND;
          phase_d = P_HDR;
          len_d   = start_full ? FLEN_W : count;
          data_d  = HEADER;
          chk_d   = '0;
        end
      end
      S_SEND: begin
        if (TX_Done_Sig) state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_SEND;
        unique case (phase)
          P_HDR: begin
            phase_d = P_LEN;
            data_d  = 8'(len_q);
            chk_d   = 8'(len_q);
          end
          P_LEN: begin
            phase_d = P_PAY;
            idx_d   = '0;
            pop     = 1'b1;
            data_d  = rd_byte;
            chk_d   = chk_q ^ rd_byte;
          end
          P_PAY: begin
            if (idx == len_q - CNT_ONE) begin
              if (CHK_EN) begin
                phase_d = P_CHK;
                data_d  = chk_q;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              idx_d  = idx + CNT_ONE;
              pop    = 1'b1;
              data_d = rd_byte;
              chk_d  = chk_q ^ rd_byte;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      phase  <= P_HDR;
      idx    <= '0;
      len_q  <= '0;
      chk_q  <= '0;
      data_q <= '0;
    end else begin
      phase  <= phase_d;
      idx    <= idx_d;
      len_q  <= len_d;
      chk_q  <= chk_d;
      data_q <= data_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ps2_q  <= 1'b0;
      ps2_qq <= 1'b0;
      kbd_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ps2_q  <= PS2_Done_Sig;
      ps2_qq <= ps2_q;
      kbd_q  <= KeyBoardData;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (capture && !push) ovf <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= kbd_q;
  end

  // Down-counter reloads on activity; reaching zero is the flush condition.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                               tmr <= TMR_LOAD;
    else if (push || start || count == '0)   tmr <= TMR_LOAD;
    else if (state == S_IDLE && tmr != '0)   tmr <= tmr - TMR_ONE;
  end

  assign TX_En_Sig    = (state == S_SEND);
  assign Busy_Sig     = (state != S_IDLE);
  assign TX_Data      = data_q;
  assign Fifo_Count   = count;
  assign Overflow_Sig = ovf;

endmodule

// File: tb/tb_ps2_uart_frame_tx.sv
// Bench for ps2_uart_frame_tx: one checksummed/flushing instance and one small no-flush instance.
module tb_ps2_uart_frame_tx;

  typedef struct { logic [7:0] d; int cnt; logic ovf; logic en; } vec_t;
  typedef struct { logic [7:0] byt; bit last; } txb_t;

  logic       clk;
  logic       rst_a, ps2_a, done_a, en_a, ovf_a, busy_a;
  logic [7:0] kbd_a, data_a;
  logic [4:0] cnt_a;
  logic       rst_b, ps2_b, done_b, en_b, ovf_b, busy_b;
  logic [7:0] kbd_b, data_b;
  logic [2:0] cnt_b;

  int   checks = 0;
  int   errors = 0;
  int   seen_a = 0;
  bit   abort_a = 0;
  txb_t exp_a[$];
  logic [7:0] mdl_a[$];

  ps2_uart_frame_tx #(.FIFO_AW(4), .FRAME_LEN(4), .HEADER(8'hA5), .CHK_EN(1'b1), .FLUSH_CYCLES(100)) dut_a (
    .CLK(clk), .RSTn(rst_a), .PS2_Done_Sig(ps2_a), .KeyBoardData(kbd_a), .TX_Done_Sig(done_a),
    .TX_En_Sig(en_a), .TX_Data(data_a), .Fifo_Count(cnt_a), .Overflow_Sig(ovf_a), .Busy_Sig(busy_a));

  ps2_uart_frame_tx #(.FIFO_AW(2), .FRAME_LEN(4), .HEADER(8'hA5), .CHK_EN(1'b0), .FLUSH_CYCLES(0)) dut_b (
    .CLK(clk), .RSTn(rst_b), .PS2_Done_Sig(ps2_b), .KeyBoardData(kbd_b), .TX_Done_Sig(done_b),
    .TX_En_Sig(en_b), .TX_Data(data_b), .Fifo_Count(cnt_b), .Overflow_Sig(ovf_b), .Busy_Sig(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected frame built from the bench's own copy of the captured bytes.
  task automatic queue_frame_a(input int n);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'(n);
    exp_a.push_back('{byt: 8'hA5, last: 1'b0});
    exp_a.push_back('{byt: 8'(n), last: 1'b0});
    for (int i = 0; i < n; i++) begin
      b = mdl_a.pop_front();
      c = c ^ b;
      exp_a.push_back('{byt: b, last: 1'b0});
    end
    exp_a.push_back('{byt: c, last: 1'b1});
  endtask

  task automatic note_a(input logic [7:0] d);
    mdl_a.push_back(d);
    if (mdl_a.size() >= 4) queue_frame_a(4);
  endtask

  task automatic push_a(input logic [7:0] d);
    @(posedge clk); #1; ps2_a = 1'b1; kbd_a = d;
    @(posedge clk); #1; ps2_a = 1'b0;
    note_a(d);
  endtask

  task automatic push_b(input logic [7:0] d);
    @(posedge clk); #1; ps2_b = 1'b1; kbd_b = d;
    @(posedge clk); #1; ps2_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int i;
    i = 0;
    while (i < budget && (exp_a.size() != 0 || busy_a)) begin
      @(negedge clk);
      i++;
    end
    check("a_drain_queue", exp_a.size(), 0);
    check("a_drain_busy", busy_a, 0);
  endtask

  // UART model for instance A: Done 10 cycles after En, checks bytes and the one-cycle gap.
  initial begin
    txb_t e;
    bit   cont;
    done_a = 1'b0;
    cont   = 1'b0;
    forever begin
      @(negedge clk);
      if (cont) begin
        check("a_gap_one_cycle", en_a, 1);
        cont = 1'b0;
      end
      if (en_a) begin
        seen_a++;
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_byte: got %0h, expected no byte", data_a);
          e = '{byt: 8'h00, last: 1'b1};
        end else begin
          e = exp_a.pop_front();
          check("a_tx_byte", data_a, e.byt);
        end
        repeat (9) @(negedge clk);
        if (!abort_a) check("a_tx_data_stable", data_a, e.byt);
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        check("a_gap_low", en_a, 0);
        cont = !e.last && !abort_a;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t tab_a[4];
    vec_t tab_b[9];
    logic [7:0] exp_b[6];
    int w;
    int hits;
    int s0;

    tab_a[0] = '{d: 8'h1C, cnt: 1, ovf: 1'b0, en: 1'b0};
    tab_a[1] = '{d: 8'h32, cnt: 2, ovf: 1'b0, en: 1'b0};
    tab_a[2] = '{d: 8'h21, cnt: 3, ovf: 1'b0, en: 1'b0};
    tab_a[3] = '{d: 8'h23, cnt: 4, ovf: 1'b0, en: 1'b0};
    for (int i = 0; i < 9; i++)
      tab_b[i] = '{d: 8'(i + 1), cnt: (i < 4) ? i + 1 : 4, ovf: (i >= 4), en: 1'b0};
    exp_b[0] = 8'hA5; exp_b[1] = 8'h04; exp_b[2] = 8'h01;
    exp_b[3] = 8'h02; exp_b[4] = 8'h03; exp_b[5] = 8'h04;

    rst_a = 1'b1; rst_b = 1'b1;
    ps2_a = 1'b0; ps2_b = 1'b0; kbd_a = '0; kbd_b = '0; done_b = 1'b0;
    #2 rst_a = 1'b0; rst_b = 1'b0;
    #1;
    check("reset_en", en_a, 0);
    check("reset_data", data_a, 0);
    check("reset_count", cnt_a, 0);
    check("reset_ovf", ovf_a, 0);
    check("reset_busy", busy_a, 0);
    #20 rst_a = 1'b1; rst_b = 1'b1;

    // Full frame A5 04 1C 32 21 23 CHK
    for (int i = 0; i < 4; i++) begin
      push_a(tab_a[i].d);
      @(posedge clk); @(negedge clk);
      check("a_table_count", cnt_a, tab_a[i].cnt);
      check("a_table_en", en_a, tab_a[i].en);
    end
    @(negedge clk);
    check("a_start_en", en_a, 1);
    check("a_start_header", data_a, 8'hA5);
    check("a_start_busy", busy_a, 1);
    wait_idle_a(400);
    check("a_count_after_frame", cnt_a, 0);

    // Level input held high captures exactly one byte, later flushed
    @(posedge clk); #1; ps2_a = 1'b1; kbd_a = 8'h5A;
    repeat (50) @(posedge clk);
    #1 ps2_a = 1'b0;
    note_a(8'h5A);
    @(posedge clk); @(negedge clk);
    check("a_level_count", cnt_a, 1);
    queue_frame_a(mdl_a.size());
    wait_idle_a(400);

    // Flush timing: start exactly 100 idle cycles after capture
    push_a(8'hF0);
    queue_frame_a(mdl_a.size());
    @(posedge clk); @(negedge clk);
    check("a_flush_count", cnt_a, 1);
    repeat (100) @(negedge clk);
    check("a_flush_not_early", en_a, 0);
    @(negedge clk);
    check("a_flush_start", en_a, 1);
    wait_idle_a(400);
    check("a_flush_count_end", cnt_a, 0);

    // Concurrency: push lands on the same edge as the first payload pop
    push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44);
    w = 0;
    while (w < 100 && !(en_a && data_a == 8'h04)) begin
      @(negedge clk);
      w++;
    end
    check("a_conc_len_seen", en_a && data_a == 8'h04, 1);
    repeat (9) @(negedge clk);
    ps2_a = 1'b1; kbd_a = 8'h55;
    @(negedge clk);
    ps2_a = 1'b0;
    note_a(8'h55);
    @(negedge clk);
    check("a_conc_push_pop_count", cnt_a, 4);
    push_a(8'h66); push_a(8'h77); push_a(8'h88);
    wait_idle_a(600);
    check("a_conc_count_end", cnt_a, 0);

    // Reset during payload
    s0 = seen_a;
    push_a(8'hC1); push_a(8'hC2); push_a(8'hC3); push_a(8'hC4);
    w = 0;
    while (w < 100 && seen_a < s0 + 3) begin
      @(negedge clk);
      w++;
    end
    check("a_rst_reached_payload", seen_a >= s0 + 3, 1);
    repeat (4) @(posedge clk);
    #3 abort_a = 1'b1; rst_a = 1'b0;
    #1;
    check("a_midrst_en", en_a, 0);
    check("a_midrst_busy", busy_a, 0);
    check("a_midrst_count", cnt_a, 0);
    check("a_midrst_data", data_a, 0);
    exp_a.delete();
    mdl_a.delete();
    @(posedge clk); #2 rst_a = 1'b1;
    hits = 0;
    repeat (200) begin
      @(negedge clk);
      if (en_a) hits++;
    end
    check("a_no_tx_after_reset", hits, 0);
    abort_a = 1'b0;
    push_a(8'h0D); push_a(8'h0E); push_a(8'h0F); push_a(8'h10);
    wait_idle_a(400);

    // Instance B: overflow with UART stalled
    for (int i = 0; i < 9; i++) begin
      push_b(tab_b[i].d);
      @(posedge clk); @(negedge clk);
      check("b_table_count", cnt_b, tab_b[i].cnt);
      check("b_table_ovf", ovf_b, tab_b[i].ovf);
    end
    check("b_stalled_en", en_b, 1);
    for (int i = 0; i < 6; i++) begin
      w = 0;
      while (!en_b && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("b_en_wait", en_b, 1);
      check("b_tx_byte", data_b, exp_b[i]);
      done_b = 1'b1;
      @(negedge clk);
      done_b = 1'b0;
      check("b_gap_low", en_b, 0);
    end
    @(negedge clk);
    check("b_count_end", cnt_b, 0);
    check("b_ovf_sticky", ovf_b, 1);
    check("b_busy_end", busy_b, 0);

    // Flush disabled: a lone byte is never sent; Done outside SEND ignored
    push_b(8'h77);
    @(posedge clk); @(negedge clk);
    check("b_lone_count", cnt_b, 1);
    hits = 0;
    repeat (300) begin
      @(negedge clk);
      if (en_b) hits++;
    end
    check("b_no_flush", hits, 0);
    done_b = 1'b1;
    @(negedge clk);
    done_b = 1'b0;
    @(negedge clk);
    check("b_done_ignored_en", en_b, 0);
    check("b_done_ignored_count", cnt_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
